// File: rtl/fsm_counter_run.sv
// fsm_counter_run: run/done controller that runs a latched job length K, then pulses done
//
// Ports:
//   clk        in   1          single clock, all logic on posedge
//   reset_n    in   1          synchronous active-low reset
//   i_run      in   1          start pulse, accepted only while idle
//   i_num_cnt  in   CNT_WIDTH  job length K, latched together with i_run
//   i_abort    in   1          ends a running job without a done pulse
//   o_idle     out  1          state is S_IDLE
//   o_valid    out  1          state is S_RUN
//   o_cnt      out  CNT_WIDTH  index of the current run cycle, 0..K-1
//   o_done     out  1          one-cycle pulse after the last run cycle
//   o_err      out  1          one-cycle pulse: i_run arrived while busy
module fsm_counter_run #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_run,
  input  logic [CNT_WIDTH-1:0] i_num_cnt,
  input  logic                 i_abort,
  output logic                 o_idle,
  output logic                 o_valid,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_done,
  output logic                 o_err
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] num_q, num_d;
  logic                 err_q, err_d;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = S_IDLE;
    cnt_d   = '0;
    num_d   = num_q;
    err_d   = i_run && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (i_run) begin
          num_d   = i_num_cnt;
          state_d = (i_num_cnt != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // abort takes priority, even on the final run cycle
        if (!i_abort && cnt_q != num_q - 1'b1) begin
          state_d = S_RUN;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          state_d = i_abort ? S_IDLE : S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign o_idle  = state_q == S_IDLE;
  assign o_valid = state_q == S_RUN;
  assign o_done  = state_q == S_DONE;
  assign o_cnt   = cnt_q;
  assign o_err   = err_q;
endmodule

// File: tb/tb_fsm_counter_run.sv
// tb_fsm_counter_run: scoreboard bench for fsm_counter_run
module tb_fsm_counter_run;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_run;
  logic [7:0] i_num_cnt;
  logic       i_abort;
  logic       o_idle, o_valid, o_done, o_err;
  logic [7:0] o_cnt;
  int         total = 0;
  int         bad = 0;
  logic [11:0] exp_q[$];
  string       tag_q[$];
  fsm_counter_run #(.CNT_WIDTH(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_run(i_run),
    .i_num_cnt(i_num_cnt),
    .i_abort(i_abort),
    .o_idle(o_idle),
    .o_valid(o_valid),
    .o_cnt(o_cnt),
    .o_done(o_done),
    .o_err(o_err)
  );
  always #5 clk = ~clk;
  // expected output vector: {idle, valid, done, err, cnt}
  function automatic logic [11:0] ev(logic idle, logic valid, logic done, logic err, logic [7:0] cnt);
    return {idle, valid, done, err, cnt};
  endfunction
  function automatic logic [11:0] vi();
    return ev(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
  endfunction
  function automatic logic [11:0] vv(int c, logic err = 1'b0);
    return ev(1'b0, 1'b1, 1'b0, err, 8'(c));
  endfunction
  function automatic logic [11:0] vd();
    return ev(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
  endfunction
  task automatic chk(string tag, logic [11:0] got, logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got idle/valid/done/err=%b cnt=%0d expected idle/valid/done/err=%b cnt=%0d",
               tag, got[11:8], got[7:0], exp[11:8], exp[7:0]);
    end
  endtask
  // drive one cycle of inputs, queue what the outputs must show after the edge,
  // then compare against the oldest queued expectation
  task automatic cyc(string tag, logic rstn, logic run, logic [7:0] num, logic abort, logic [11:0] exp);
    logic [11:0] e;
    string       t;
    reset_n   = rstn;
    i_run     = run;
    i_num_cnt = num;
    i_abort   = abort;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, {o_idle, o_valid, o_done, o_err, o_cnt}, e);
  endtask
  // idle cycles carry random i_num_cnt to show it is ignored
  task automatic nop(string tag, logic [11:0] exp);
    cyc(tag, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0, exp);
  endtask
  task automatic job(string tag, int k);
    if (k == 0) begin
      cyc({tag, "_start0"}, 1'b1, 1'b1, 8'd0, 1'b0, vd());
    end else begin
      cyc({tag, "_start"}, 1'b1, 1'b1, 8'(k), 1'b0, vv(0));
      for (int i = 1; i < k; i++) nop({tag, "_run"}, vv(i));
      nop({tag, "_done"}, vd());
    end
    nop({tag, "_idle"}, vi());
  endtask
  initial begin
    cyc("reset", 1'b0, 1'b1, 8'd9, 1'b1, vi());
    nop("post_reset", vi());
    cyc("abort_in_idle", 1'b1, 1'b0, 8'd3, 1'b1, vi());
    job("k5", 5);
    job("k1", 1);
    job("k0", 0);
    job("k255", 255);
    // abort while o_cnt shows 3
    cyc("ab_start", 1'b1, 1'b1, 8'd10, 1'b0, vv(0));
    for (int i = 1; i <= 3; i++) nop("ab_run", vv(i));
    cyc("ab_abort", 1'b1, 1'b0, 8'd10, 1'b1, vi());
    nop("ab_nodone", vi());
    // abort on the last run cycle beats completion
    cyc("ablast_start", 1'b1, 1'b1, 8'd3, 1'b0, vv(0));
    nop("ablast_run", vv(1));
    nop("ablast_run", vv(2));
    cyc("ablast_abort", 1'b1, 1'b0, 8'd3, 1'b1, vi());
    nop("ablast_nodone", vi());
    // busy start while o_cnt shows 2, then again during done
    cyc("err_start", 1'b1, 1'b1, 8'd10, 1'b0, vv(0));
    nop("err_run", vv(1));
    nop("err_run", vv(2));
    cyc("err_busy", 1'b1, 1'b1, 8'd7, 1'b0, vv(3, 1'b1));
    for (int i = 4; i <= 9; i++) nop("err_run", vv(i));
    nop("err_done", vd());
    cyc("err_in_done", 1'b1, 1'b1, 8'd4, 1'b0, ev(1'b1, 1'b0, 1'b0, 1'b1, 8'd0));
    nop("err_not_accepted", vi());
    // reset mid-run at o_cnt 4, then a fresh job
    cyc("rst_start", 1'b1, 1'b1, 8'd10, 1'b0, vv(0));
    for (int i = 1; i <= 4; i++) nop("rst_run", vv(i));
    cyc("rst_mid", 1'b0, 1'b0, 8'd10, 1'b0, vi());
    nop("rst_nodone", vi());
    job("k3_after_rst", 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
